relay_mode_sequencer: RTL and testbench
=======================================

Name: relay_mode_sequencer

Overview:
- Sits downstream of the AUX_INPUT pulse-width classifier, which issues one-cycle mode reports.
- Turns those reports into safe relay drive: break-before-make dead time, a minimum hold time per mode, and a watchdog that drops both relays when reports stop arriving.
- Also owns the enable gating and a sticky fault flag for the relay board.

Parameters:
- DEAD_CYCLES, 50000: cycles with both relays off before any relay is energised (1 ms at 50 MHz); must be ≥1.
- MIN_HOLD_CYCLES, 2500000: minimum cycles a relay stays on before a change is honoured (50 ms); ≥1.
- TIMEOUT_CYCLES, 5000000: watchdog period, counted in cycles without a MODE_VALID (100 ms); ≥1.
- CNT_W, 26: width of all internal counters; every parameter must be < 2^CNT_W.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  level; 0 forces relays off.
- MODE_VALID  in  1  one-cycle strobe from the classifier.
- MODE_CODE  in  2  sampled with MODE_VALID: 0 = off, 1 = mode A, 2 = mode B, 3 = reserved/illegal.
- FAULT_CLR  in  1  level/strobe; clears FAULT.
- RELAY_A  out  1  relay drive, mode A.
- RELAY_B  out  1  relay drive, mode B.
- ON_MODE  out  2  mode currently energised (0/1/2).
- BUSY  out  1  high in DEAD, or in ACTIVE with a pending request.
- FAULT  out  1  sticky watchdog/illegal-code flag.

Behaviour:
Reset and output rules
- Reset (async assert, sync release): state IDLE, all outputs 0, counters 0, pending target 0.
- Outputs are registered. RELAY_A and RELAY_B are never both 1, in any state.

States
- IDLE: relays off.
- DEAD: relays off; dead counter running toward target T.
- ACTIVE: exactly one relay on; hold counter running.
- SAFE: relays off, FAULT = 1.

Priority per cycle: reset > ENABLE = 0 > fault detection > mode request.

ENABLE = 0
- Next edge: IDLE, relays off, ON_MODE = 0, pending cleared, watchdog cleared.
- FAULT is retained.
- MODE_VALID is ignored while ENABLE = 0.

Fault detection (only with ENABLE = 1)
- MODE_VALID with MODE_CODE = 3 → SAFE, FAULT = 1.
- Watchdog counts cycles since the last MODE_VALID. It is active only in DEAD/ACTIVE and cleared on every MODE_VALID and on entry to IDLE.
- Watchdog reaching TIMEOUT_CYCLES → SAFE, FAULT = 1.
- SAFE exits only on FAULT_CLR = 1: go to IDLE and clear FAULT on the next edge. MODE_VALID is ignored in SAFE.
- FAULT_CLR outside SAFE has no effect.

IDLE
- MODE_VALID, code 1/2 → DEAD with T = code, dead counter = 0.
- Code 0 is ignored.

DEAD
- Counter increments each cycle.
- When counter = DEAD_CYCLES−1 → ACTIVE, RELAY_T = 1, ON_MODE = T.
- Latency: a strobe at edge k gives the relay high after edge k+DEAD_CYCLES.
- New MODE_VALID during DEAD: code 1/2 replaces T without restarting the counter (last wins); code 0 → IDLE next edge.
- If a strobe coincides with the terminal count, the strobe's code is used as T.

ACTIVE
- Hold counter starts at 0 on entry, increments, saturates at MIN_HOLD_CYCLES.
- MODE_VALID with code = ON_MODE: refreshes the watchdog only; also cancels any pending request.
- MODE_VALID with a different code:
  - Hold satisfied: act at the next edge — relays off, ON_MODE = 0, then DEAD (code 1/2) or IDLE (code 0).
  - Hold not satisfied: latch the pending request (last wins), BUSY = 1, and act on the cycle the hold counter reaches MIN_HOLD_CYCLES.
- A direct mode-A ↔ mode-B swap always passes through DEAD.

Test Plan:
Use DEAD_CYCLES = 4, MIN_HOLD_CYCLES = 10, TIMEOUT_CYCLES = 50 for all scenarios.
- Reset, ENABLE = 1, MODE_VALID/code 1 at edge 5 → RELAY_A rises after edge 9, ON_MODE = 1; RELAY_B = 0 throughout; BUSY high in edges 5–8.
- In ACTIVE mode 1, code 2 strobed 3 cycles after entry → BUSY = 1; RELAY_A falls at hold completion (entry+10); RELAY_B rises 4 cycles later; no cycle has both relays high.
- In DEAD toward 1, strobe code 2 at dead count 2 → RELAY_B (not A) rises at the original terminal edge. Separately, strobe code 0 mid-DEAD → IDLE, no relay ever set.
- In ACTIVE, strobes stop → at 50 cycles after the last strobe, relays off and FAULT = 1. Strobes in SAFE are ignored. FAULT_CLR → IDLE, FAULT = 0. Code 3 strobe from ACTIVE → same fault result.
- ENABLE dropped mid-DEAD and mid-ACTIVE → relays off next edge, ON_MODE = 0. Re-enable plus a code 2 strobe → full 4-cycle dead time is applied.
- RESET_N asserted asynchronously between clock edges while RELAY_B = 1 → RELAY_B = 0 immediately, without waiting for a clock edge; state IDLE after release.

Source files
------------

// File: rtl/relay_mode_sequencer.sv
// Relay mode sequencer: break-before-make drive of two relays with
// minimum hold, report watchdog and sticky fault.
module relay_mode_sequencer #(
  parameter int DEAD_CYCLES     = 50000,
  parameter int MIN_HOLD_CYCLES = 2500000,
  parameter int TIMEOUT_CYCLES  = 5000000,
  parameter int CNT_W           = 26
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       MODE_VALID,
  input  logic [1:0] MODE_CODE,
  input  logic       FAULT_CLR,
  output logic       RELAY_A,
  output logic       RELAY_B,
  output logic [1:0] ON_MODE,
  output logic       BUSY,
  output logic       FAULT
);

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    ACTIVE,
    SAFE
  } state_t;

  localparam logic [CNT_W-1:0] DEAD_END =
    CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_END =
    CNT_W'(MIN_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX =
    CNT_W'(MIN_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] WD_END =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] dead_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] wd_cnt;
  logic [1:0]       tgt;
  logic [1:0]       pend;
  logic             pend_v;

  logic       code_go;
  logic       code_off;
  logic       code_bad;
  logic       same_code;
  logic       wd_trip;
  logic       dead_end;
  logic       hold_done;
  logic       leave_now;
  logic [1:0] dead_tgt;
  logic [1:0] leave_code;

  assign code_go = MODE_VALID &&
    (MODE_CODE == 2'd1 || MODE_CODE == 2'd2);
  assign code_off  = MODE_VALID && MODE_CODE == 2'd0;
  assign code_bad  = MODE_VALID && MODE_CODE == 2'd3;
  assign same_code = MODE_VALID && MODE_CODE == ON_MODE;

  assign wd_trip = (state == DEAD || state == ACTIVE) &&
    !MODE_VALID && wd_cnt == WD_END;

  assign dead_end = dead_cnt == DEAD_END;
  // Done one cycle early: the edge that acts completes the hold.
  assign hold_done = hold_cnt >= HOLD_END;

  assign dead_tgt = code_go ? MODE_CODE : tgt;

  assign leave_now = hold_done &&
    ((MODE_VALID && !same_code) || (!MODE_VALID && pend_v));
  assign leave_code = MODE_VALID ? MODE_CODE : pend;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      dead_cnt <= '0;
      hold_cnt <= '0;
      wd_cnt   <= '0;
      tgt      <= 2'd0;
      pend     <= 2'd0;
      pend_v   <= 1'b0;
      RELAY_A  <= 1'b0;
      RELAY_B  <= 1'b0;
      ON_MODE  <= 2'd0;
      BUSY     <= 1'b0;
      FAULT    <= 1'b0;
    end else if (!ENABLE) begin
      state    <= IDLE;
      dead_cnt <= '0;
      hold_cnt <= '0;
      wd_cnt   <= '0;
      tgt      <= 2'd0;
      pend     <= 2'd0;
      pend_v   <= 1'b0;
      RELAY_A  <= 1'b0;
      RELAY_B  <= 1'b0;
      ON_MODE  <= 2'd0;
      BUSY     <= 1'b0;
    end else if (state == SAFE) begin
      if (FAULT_CLR) begin
        state <= IDLE;
        FAULT <= 1'b0;
      end
    end else if (code_bad || wd_trip) begin
      state    <= SAFE;
      FAULT    <= 1'b1;
      wd_cnt   <= '0;
      pend     <= 2'd0;
      pend_v   <= 1'b0;
      RELAY_A  <= 1'b0;
      RELAY_B  <= 1'b0;
      ON_MODE  <= 2'd0;
      BUSY     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (code_go) begin
            state    <= DEAD;
            tgt      <= MODE_CODE;
            dead_cnt <= '0;
            BUSY     <= 1'b1;
          end
        end
        DEAD: begin
          wd_cnt <= MODE_VALID ? '0 : wd_cnt + 1'b1;
          if (code_off) begin
            state    <= IDLE;
            wd_cnt   <= '0;
            dead_cnt <= '0;
            BUSY     <= 1'b0;
          end else if (dead_end) begin
            state    <= ACTIVE;
            hold_cnt <= '0;
            pend_v   <= 1'b0;
            RELAY_A  <= dead_tgt == 2'd1;
            RELAY_B  <= dead_tgt == 2'd2;
            ON_MODE  <= dead_tgt;
            BUSY     <= 1'b0;
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
            tgt      <= dead_tgt;
          end
        end
        ACTIVE: begin
          wd_cnt <= MODE_VALID ? '0 : wd_cnt + 1'b1;
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
          if (leave_now) begin
            RELAY_A <= 1'b0;
            RELAY_B <= 1'b0;
            ON_MODE <= 2'd0;
            pend    <= 2'd0;
            pend_v  <= 1'b0;
            if (leave_code == 2'd0) begin
              state  <= IDLE;
              wd_cnt <= '0;
              BUSY   <= 1'b0;
            end else begin
              state    <= DEAD;
              tgt      <= leave_code;
              dead_cnt <= '0;
              BUSY     <= 1'b1;
            end
          end else if (MODE_VALID) begin
            pend   <= same_code ? 2'd0 : MODE_CODE;
            pend_v <= !same_code;
            BUSY   <= !same_code;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relay_mode_sequencer.sv
// Bench for relay_mode_sequencer: directed scenarios plus random
// stimulus, checked every cycle against a timestamp-based model.
module tb_relay_mode_sequencer;

  localparam int DEAD = 4;
  localparam int HOLD = 10;
  localparam int TO   = 50;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic       ENABLE;
  logic       MODE_VALID;
  logic [1:0] MODE_CODE;
  logic       FAULT_CLR;
  logic       RELAY_A;
  logic       RELAY_B;
  logic [1:0] ON_MODE;
  logic       BUSY;
  logic       FAULT;

  relay_mode_sequencer #(
    .DEAD_CYCLES    (DEAD),
    .MIN_HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (26)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .ENABLE    (ENABLE),
    .MODE_VALID(MODE_VALID),
    .MODE_CODE (MODE_CODE),
    .FAULT_CLR (FAULT_CLR),
    .RELAY_A   (RELAY_A),
    .RELAY_B   (RELAY_B),
    .ON_MODE   (ON_MODE),
    .BUSY      (BUSY),
    .FAULT     (FAULT)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: phase names plus edge timestamps of key events.
  localparam int M_IDLE = 0;
  localparam int M_DEAD = 1;
  localparam int M_ACT  = 2;
  localparam int M_SAFE = 3;

  int m_ph;
  int m_mode;
  int m_tgt;
  int m_pend;
  int m_fault;
  int t_dead;
  int t_act;
  int t_last;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ph    = M_IDLE;
    m_mode  = 0;
    m_tgt   = 0;
    m_pend  = -1;
    m_fault = 0;
    t_dead  = 0;
    t_act   = 0;
    t_last  = cyc;
  endtask

  task automatic model_step();
    int mv;
    int code;
    mv   = int'(MODE_VALID);
    code = int'(MODE_CODE);
    if (!ENABLE) begin
      m_ph   = M_IDLE;
      m_mode = 0;
      m_pend = -1;
    end else if (m_ph == M_SAFE) begin
      if (FAULT_CLR) begin
        m_ph    = M_IDLE;
        m_fault = 0;
      end
    end else if ((mv != 0 && code == 3) ||
                 ((m_ph == M_DEAD || m_ph == M_ACT) &&
                  mv == 0 && cyc - t_last >= TO)) begin
      m_ph    = M_SAFE;
      m_fault = 1;
      m_mode  = 0;
      m_pend  = -1;
    end else begin
      if (mv != 0) t_last = cyc;
      case (m_ph)
        M_IDLE: begin
          if (mv != 0 && code != 0) begin
            m_ph   = M_DEAD;
            m_tgt  = code;
            t_dead = cyc;
          end
        end
        M_DEAD: begin
          if (mv != 0 && code == 0) begin
            m_ph = M_IDLE;
          end else begin
            if (mv != 0) m_tgt = code;
            if (cyc - t_dead == DEAD) begin
              m_ph   = M_ACT;
              m_mode = m_tgt;
              t_act  = cyc;
              m_pend = -1;
            end
          end
        end
        default: begin
          if (mv != 0) m_pend = (code == m_mode) ? -1 : code;
          if (m_pend >= 0 && cyc - t_act >= HOLD) begin
            m_mode = 0;
            if (m_pend == 0) begin
              m_ph = M_IDLE;
            end else begin
              m_ph   = M_DEAD;
              m_tgt  = m_pend;
              t_dead = cyc;
            end
            m_pend = -1;
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    cyc++;
    model_step();
    #1;
    chk("relay_a", 32'(RELAY_A), 32'(m_ph == M_ACT && m_mode == 1));
    chk("relay_b", 32'(RELAY_B), 32'(m_ph == M_ACT && m_mode == 2));
    chk("on_mode", 32'(ON_MODE), (m_ph == M_ACT) ? m_mode : 0);
    chk("busy", 32'(BUSY),
        32'(m_ph == M_DEAD || (m_ph == M_ACT && m_pend >= 0)));
    chk("fault", 32'(FAULT), m_fault);
    chk("exclusive", 32'(RELAY_A & RELAY_B), 0);
  endtask

  task automatic strobe(input logic [1:0] c);
    MODE_VALID = 1'b1;
    MODE_CODE  = c;
    tick();
    MODE_VALID = 1'b0;
    MODE_CODE  = 2'd0;
  endtask

  int p_tab[6] = '{25, 3, 10, 1, 40, 8};

  initial begin
    RESET_N    = 1'b0;
    ENABLE     = 1'b0;
    MODE_VALID = 1'b0;
    MODE_CODE  = 2'd0;
    FAULT_CLR  = 1'b0;
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #3;
    chk("rst_a", 32'(RELAY_A), 0);
    chk("rst_b", 32'(RELAY_B), 0);
    chk("rst_mode", 32'(ON_MODE), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_fault", 32'(FAULT), 0);
    RESET_N = 1'b1;
    ENABLE  = 1'b1;
    cyc     = 0;

    // Strobe at edge 5, relay A after edge 9
    repeat (4) tick();
    strobe(2'd1);
    repeat (3) tick();
    chk("tp1_busy_e8", 32'(BUSY), 1);
    chk("tp1_a_e8", 32'(RELAY_A), 0);
    tick();
    chk("tp1_a_e9", 32'(RELAY_A), 1);
    chk("tp1_mode_e9", 32'(ON_MODE), 1);

    // Early swap request waits for hold completion
    repeat (2) tick();
    strobe(2'd2);
    chk("tp2_busy", 32'(BUSY), 1);
    repeat (6) tick();
    chk("tp2_a_hold", 32'(RELAY_A), 1);
    tick();
    chk("tp2_a_off", 32'(RELAY_A), 0);
    repeat (3) tick();
    chk("tp2_b_dead", 32'(RELAY_B), 0);
    tick();
    chk("tp2_b_on", 32'(RELAY_B), 1);

    // Retarget in DEAD keeps original terminal edge
    repeat (10) tick();
    strobe(2'd1);
    tick();
    tick();
    strobe(2'd2);
    chk("tp3_b_pre", 32'(RELAY_B), 0);
    tick();
    chk("tp3_b_on", 32'(RELAY_B), 1);
    chk("tp3_a_off", 32'(RELAY_A), 0);
    repeat (10) tick();
    strobe(2'd1);
    tick();
    strobe(2'd0);
    repeat (6) tick();
    chk("tp3_cancel_a", 32'(RELAY_A), 0);
    chk("tp3_cancel_busy", 32'(BUSY), 0);

    // Watchdog, ignored strobes in SAFE, clear, illegal code
    strobe(2'd1);
    repeat (49) tick();
    chk("tp4_wd_pre", 32'(FAULT), 0);
    chk("tp4_a_pre", 32'(RELAY_A), 1);
    tick();
    chk("tp4_wd_fault", 32'(FAULT), 1);
    chk("tp4_wd_a", 32'(RELAY_A), 0);
    strobe(2'd2);
    repeat (3) tick();
    chk("tp4_safe_b", 32'(RELAY_B), 0);
    chk("tp4_safe_fault", 32'(FAULT), 1);
    FAULT_CLR = 1'b1;
    tick();
    FAULT_CLR = 1'b0;
    chk("tp4_clr", 32'(FAULT), 0);
    strobe(2'd1);
    repeat (4) tick();
    chk("tp4_a_on", 32'(RELAY_A), 1);
    strobe(2'd3);
    chk("tp4_bad_fault", 32'(FAULT), 1);
    chk("tp4_bad_a", 32'(RELAY_A), 0);
    FAULT_CLR = 1'b1;
    tick();
    FAULT_CLR = 1'b0;

    // ENABLE drop mid-DEAD and mid-ACTIVE
    strobe(2'd1);
    tick();
    tick();
    ENABLE = 1'b0;
    tick();
    chk("tp5_dead_busy", 32'(BUSY), 0);
    ENABLE = 1'b1;
    strobe(2'd2);
    repeat (3) tick();
    chk("tp5_b_pre", 32'(RELAY_B), 0);
    tick();
    chk("tp5_b_on", 32'(RELAY_B), 1);
    ENABLE = 1'b0;
    tick();
    chk("tp5_b_off", 32'(RELAY_B), 0);
    chk("tp5_mode", 32'(ON_MODE), 0);
    ENABLE = 1'b1;
    strobe(2'd2);
    repeat (3) tick();
    chk("tp5_re_pre", 32'(RELAY_B), 0);
    tick();
    chk("tp5_re_on", 32'(RELAY_B), 1);

    // Asynchronous reset between edges
    #3;
    RESET_N = 1'b0;
    #1;
    chk("tp6_async_b", 32'(RELAY_B), 0);
    chk("tp6_async_mode", 32'(ON_MODE), 0);
    model_reset();
    #2;
    RESET_N = 1'b1;
    tick();
    chk("tp6_idle_busy", 32'(BUSY), 0);

    // Random segments with varying strobe density
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 500; i++) begin
        int unsigned r;
        ENABLE     = $urandom_range(0, 99) >= 3;
        MODE_VALID = $urandom_range(0, 99) < p_tab[s];
        r          = $urandom_range(0, 99);
        MODE_CODE  = (r < 3) ? 2'd3 : 2'(r % 3);
        FAULT_CLR  = $urandom_range(0, 99) < 5;
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
